acc_controller_gen2: RTL and testbench

Parametrised second-generation control unit for the accumulator datapath. It replaces one-hot instruction strobes with a decoded opcode and adds LOAD, JMP, HALT and illegal-opcode handling. Memory accesses use a MEM_RDY wait handshake with a timeout. Overflow traps, when enabled, redirect the PC to a vector. It drives the existing PC/IR/D/AC registers, ALU and memory strobes.

---
 rtl/acc_controller_gen2_pkg.sv | 29 ++
 rtl/acc_controller_gen2_if.sv | 41 ++++
 rtl/acc_controller_gen2_mem_wait_timer.sv | 36 +++
 rtl/acc_controller_gen2.sv | 155 +++++++++++++++
 tb/tb_acc_controller_gen2.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/acc_controller_gen2_pkg.sv
// Shared types and constants for the second-generation accumulator controller.
package acc_controller_gen2_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_OPRD   = 4'd3,
        S_EXEC   = 4'd4,
        S_WRITE  = 4'd5,
        S_BRANCH = 4'd6,
        S_TRAP   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_BNZ   = 3'd5,
        OP_JMP   = 3'd6,
        OP_HALT  = 3'd7
    } opc_t;

endpackage

// File: rtl/acc_controller_gen2_if.sv
// Controller <-> datapath signal bundle: status inputs in, register/memory strobes out.
interface acc_controller_gen2_if #(
    parameter int unsigned OPC_W = 4
);
    import acc_controller_gen2_pkg::*;

    logic             CLR;
    logic [OPC_W-1:0] OPCODE;
    logic             ZERO;
    logic             OVERFLOW;
    logic             MEM_RDY;

    logic             ADDSUB;
    logic             LD_SRC;
    logic             CL_AC;
    logic             LD_AC;
    logic             LD_D;
    logic             LD_IR;
    logic             LD_PC;
    logic             PC_CNT;
    logic             PC_VEC;
    logic             MEM_EN;
    logic             RORW;
    logic             DORPC;
    logic             TRAP_FLAG;
    logic             HALTED;
    logic [STATE_W-1:0] STATE;

    modport master (
        input  CLR, OPCODE, ZERO, OVERFLOW, MEM_RDY,
        output ADDSUB, LD_SRC, CL_AC, LD_AC, LD_D, LD_IR, LD_PC, PC_CNT,
               PC_VEC, MEM_EN, RORW, DORPC, TRAP_FLAG, HALTED, STATE
    );

    modport slave (
        output CLR, OPCODE, ZERO, OVERFLOW, MEM_RDY,
        input  ADDSUB, LD_SRC, CL_AC, LD_AC, LD_D, LD_IR, LD_PC, PC_CNT,
               PC_VEC, MEM_EN, RORW, DORPC, TRAP_FLAG, HALTED, STATE
    );

endinterface

// File: rtl/acc_controller_gen2_mem_wait_timer.sv
// Counts consecutive MEM_RDY-low cycles in a memory wait state; expire_o fires on
// the MEM_TIMEOUT-th such cycle unless the access completes in that same cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    input  logic rdy_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    always_comb begin
        stall    = wait_i && !rdy_i && (MEM_TIMEOUT != 0);
        expire_o = stall && (cnt_q == LAST);
        cnt_d    = '0;
        if (stall && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acc_controller_gen2.sv
// Accumulator control FSM: decoded-opcode sequencing, memory wait handshake with
// timeout, overflow/illegal-opcode traps and a sticky trap flag.
module acc_controller_gen2
    import acc_controller_gen2_pkg::*;
#(
    parameter int unsigned OPC_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          TRAP_ON_OVF = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    acc_controller_gen2_if.master bus
);

    state_t state_q, state_d;
    logic   flag_q, flag_d;
    logic   arm_q;
    logic   expire;
    logic   in_wait;
    logic   illegal;
    opc_t   op;

    assign op      = opc_t'(bus.OPCODE[2:0]);
    assign illegal = (OPC_W > 3) && ((bus.OPCODE >> 3) != '0);
    assign in_wait = (state_q == S_FETCH) || (state_q == S_OPRD) || (state_q == S_WRITE);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .wait_i   (in_wait),
        .rdy_i    (bus.MEM_RDY),
        .expire_o (expire)
    );

    // arm_q holds IDLE for one extra cycle after reset release, so the first
    // FETCH lands on the second rising edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            flag_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            arm_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        flag_d     = flag_q;
        bus.ADDSUB = 1'b0;
        bus.LD_SRC = 1'b0;
        bus.CL_AC  = 1'b0;
        bus.LD_AC  = 1'b0;
        bus.LD_D   = 1'b0;
        bus.LD_IR  = 1'b0;
        bus.LD_PC  = 1'b0;
        bus.PC_CNT = 1'b0;
        bus.PC_VEC = 1'b0;
        bus.MEM_EN = 1'b0;
        bus.RORW   = 1'b0;
        bus.DORPC  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.CL_AC = 1'b1;
                if (arm_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.MEM_EN = 1'b1;
                bus.RORW   = 1'b1;
                if (bus.CLR) begin
                    bus.CL_AC = 1'b1;
                    flag_d    = 1'b0;
                end
                if (bus.MEM_RDY) begin
                    bus.LD_IR  = 1'b1;
                    bus.PC_CNT = 1'b1;
                    state_d    = S_DECODE;
                end else if (expire) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_TRAP;
                end else begin
                    unique case (op)
                        OP_NOP:                  state_d = S_FETCH;
                        OP_LOAD, OP_ADD, OP_SUB: state_d = S_OPRD;
                        OP_STORE:                state_d = S_WRITE;
                        OP_BNZ:                  state_d = bus.ZERO ? S_FETCH : S_BRANCH;
                        OP_JMP:                  state_d = S_BRANCH;
                        OP_HALT:                 state_d = S_HALT;
                        default:                 state_d = S_TRAP;
                    endcase
                end
            end
            S_OPRD: begin
                bus.MEM_EN = 1'b1;
                bus.RORW   = 1'b1;
                bus.DORPC  = 1'b1;
                if (bus.MEM_RDY) begin
                    bus.LD_D = 1'b1;
                    state_d  = S_EXEC;
                end else if (expire) begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                bus.LD_AC  = 1'b1;
                bus.ADDSUB = (op == OP_SUB);
                bus.LD_SRC = (op == OP_LOAD);
                if (bus.OVERFLOW && TRAP_ON_OVF && (op == OP_ADD || op == OP_SUB)) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WRITE: begin
                bus.MEM_EN = 1'b1;
                bus.DORPC  = 1'b1;
                if (bus.MEM_RDY) begin
                    state_d = S_FETCH;
                end else if (expire) begin
                    state_d = S_TRAP;
                end
            end
            S_BRANCH: begin
                bus.LD_PC = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                bus.LD_PC  = 1'b1;
                bus.PC_VEC = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flag is registered alongside the state, so it reads 1 from the TRAP cycle on.
        if (state_d == S_TRAP) flag_d = 1'b1;
    end

    assign bus.TRAP_FLAG = flag_q;
    assign bus.HALTED    = (state_q == S_HALT);
    assign bus.STATE     = state_q;

endmodule

// File: tb/tb_acc_controller_gen2.sv
// Directed scoreboard bench for acc_controller_gen2: per-cycle expected state and
// strobe vectors are queued by the stimulus and checked by a negedge monitor.
module tb_acc_controller_gen2;

    localparam logic [13:0] CLAC   = 14'h2000;
    localparam logic [13:0] LDAC   = 14'h1000;
    localparam logic [13:0] LDD    = 14'h0800;
    localparam logic [13:0] LDIR   = 14'h0400;
    localparam logic [13:0] LDPC   = 14'h0200;
    localparam logic [13:0] PCCNT  = 14'h0100;
    localparam logic [13:0] PCVEC  = 14'h0080;
    localparam logic [13:0] MEM    = 14'h0040;
    localparam logic [13:0] RD     = 14'h0020;
    localparam logic [13:0] DORPC  = 14'h0010;
    localparam logic [13:0] ADDSUB = 14'h0008;
    localparam logic [13:0] LDSRC  = 14'h0004;
    localparam logic [13:0] TRAPF  = 14'h0002;
    localparam logic [13:0] HALTD  = 14'h0001;
    localparam logic [13:0] NONE   = 14'h0000;
    localparam logic [13:0] FETCHR = MEM | RD | LDIR | PCCNT;

    typedef struct {
        logic [17:0] v;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

    acc_controller_gen2_if #(.OPC_W(4)) bus ();

    acc_controller_gen2 #(.OPC_W(4), .MEM_TIMEOUT(15), .TRAP_ON_OVF(1'b1)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    function automatic logic [17:0] actual();
        return {bus.STATE, bus.CL_AC, bus.LD_AC, bus.LD_D, bus.LD_IR, bus.LD_PC,
                bus.PC_CNT, bus.PC_VEC, bus.MEM_EN, bus.RORW, bus.DORPC,
                bus.ADDSUB, bus.LD_SRC, bus.TRAP_FLAG, bus.HALTED};
    endfunction

    always @(negedge clk) begin
        if (!done && q.size() > 0) begin
            exp_t e;
            logic [17:0] a;
            e = q.pop_front();
            a = actual();
            tests++;
            if (a !== e.v) begin
                fails++;
                $display("FAIL %s: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                         e.name, a[17:14], a[13:0], e.v[17:14], e.v[13:0]);
            end
        end
    end

    task automatic cyc(input string nm, input logic [3:0] opc, input logic rdy,
                       input logic z, input logic ov, input logic cl,
                       input logic [3:0] st, input logic [13:0] m);
        @(posedge clk);
        #1;
        bus.OPCODE   = opc;
        bus.MEM_RDY  = rdy;
        bus.ZERO     = z;
        bus.OVERFLOW = ov;
        bus.CLR      = cl;
        q.push_back('{v: {st, m}, name: nm});
    endtask

    task automatic rst_cyc(input string nm, input logic rn);
        @(posedge clk);
        #1;
        rst_n = rn;
        q.push_back('{v: {4'd0, CLAC}, name: nm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bus.OPCODE = '0; bus.MEM_RDY = 1'b1; bus.ZERO = 1'b0;
        bus.OVERFLOW = 1'b0; bus.CLR = 1'b0;

        rst_cyc("reset", 1'b0);
        rst_cyc("release", 1'b1);
        cyc("idle2", 4'd0, 1, 0, 0, 0, 4'd0, CLAC);

        // NOP
        cyc("nop_fetch",  4'd0, 1, 0, 0, 0, 4'd1, FETCHR);
        cyc("nop_decode", 4'd0, 1, 0, 0, 0, 4'd2, NONE);

        // ADD with two MEM_RDY-low cycles in OPRD
        cyc("add_fetch",  4'd3, 1, 0, 0, 0, 4'd1, FETCHR);
        cyc("add_decode", 4'd3, 1, 0, 0, 0, 4'd2, NONE);
        cyc("add_oprd1",  4'd3, 0, 0, 0, 0, 4'd3, MEM | RD | DORPC);
        cyc("add_oprd2",  4'd3, 0, 0, 0, 0, 4'd3, MEM | RD | DORPC);
        cyc("add_oprd3",  4'd3, 1, 0, 0, 0, 4'd3, MEM | RD | DORPC | LDD);
        cyc("add_exec",   4'd3, 1, 0, 0, 0, 4'd4, LDAC);

        // SUB with overflow -> TRAP, flag held until CLR in FETCH
        cyc("sub_fetch",  4'd4, 1, 0, 0, 0, 4'd1, FETCHR);
        cyc("sub_decode", 4'd4, 1, 0, 0, 0, 4'd2, NONE);
        cyc("sub_oprd",   4'd4, 1, 0, 0, 0, 4'd3, MEM | RD | DORPC | LDD);
        cyc("sub_exec",   4'd4, 1, 0, 1, 0, 4'd4, LDAC | ADDSUB);
        cyc("ovf_trap",   4'd4, 1, 0, 0, 0, 4'd7, LDPC | PCVEC | TRAPF);
        cyc("flag_hold",  4'd1, 0, 0, 0, 0, 4'd1, MEM | RD | TRAPF);
        cyc("flag_clr",   4'd1, 1, 0, 0, 1, 4'd1, FETCHR | CLAC | TRAPF);

        // LOAD
        cyc("ld_decode",  4'd1, 1, 0, 0, 0, 4'd2, NONE);
        cyc("ld_oprd",    4'd1, 1, 0, 0, 0, 4'd3, MEM | RD | DORPC | LDD);
        cyc("ld_exec",    4'd1, 1, 0, 1, 0, 4'd4, LDAC | LDSRC);

        // BNZ taken, then not taken
        cyc("bnz_fetch",  4'd5, 1, 0, 0, 0, 4'd1, FETCHR);
        cyc("bnz_decode", 4'd5, 1, 0, 0, 0, 4'd2, NONE);
        cyc("bnz_branch", 4'd5, 1, 1, 0, 0, 4'd6, LDPC);
        cyc("bnz_fetch2", 4'd5, 1, 1, 0, 0, 4'd1, FETCHR);
        cyc("bnz_nt_dec", 4'd5, 1, 1, 0, 0, 4'd2, NONE);

        // JMP
        cyc("jmp_fetch",  4'd6, 1, 0, 0, 0, 4'd1, FETCHR);
        cyc("jmp_decode", 4'd6, 1, 0, 0, 0, 4'd2, NONE);
        cyc("jmp_branch", 4'd6, 1, 0, 0, 0, 4'd6, LDPC);

        // STORE timeout: 15 low cycles -> TRAP
        cyc("st_fetch",   4'd2, 1, 0, 0, 0, 4'd1, FETCHR);
        cyc("st_decode",  4'd2, 1, 0, 0, 0, 4'd2, NONE);
        for (int i = 0; i < 15; i++) cyc("st_wait", 4'd2, 0, 0, 0, 0, 4'd5, MEM | DORPC);
        cyc("to_trap",    4'd2, 1, 0, 0, 0, 4'd7, LDPC | PCVEC | TRAPF);
        cyc("to_clr",     4'd2, 1, 0, 0, 1, 4'd1, FETCHR | CLAC | TRAPF);
        cyc("st2_decode", 4'd2, 1, 0, 0, 0, 4'd2, NONE);
        // MEM_RDY coincident with the 15th wait cycle completes the write
        for (int i = 0; i < 14; i++) cyc("st2_wait", 4'd2, 0, 0, 0, 0, 4'd5, MEM | DORPC);
        cyc("st2_last",   4'd2, 1, 0, 0, 0, 4'd5, MEM | DORPC);
        cyc("st2_done",   4'd8, 1, 0, 0, 0, 4'd1, FETCHR);

        // Illegal opcode 8
        cyc("ill_decode", 4'd8, 1, 0, 0, 0, 4'd2, NONE);
        cyc("ill_trap",   4'd8, 1, 0, 0, 0, 4'd7, LDPC | PCVEC | TRAPF);
        cyc("ill_clr",    4'd3, 1, 0, 0, 1, 4'd1, FETCHR | CLAC | TRAPF);

        // Async reset in the middle of OPRD
        cyc("mr_decode",  4'd3, 1, 0, 0, 0, 4'd2, NONE);
        cyc("mr_oprd",    4'd3, 0, 0, 0, 0, 4'd3, MEM | RD | DORPC);
        rst_cyc("mr_reset", 1'b0);
        rst_cyc("mr_release", 1'b1);
        cyc("mr_idle2",   4'd7, 1, 0, 0, 0, 4'd0, CLAC);

        // HALT sticks regardless of inputs
        cyc("h_fetch",    4'd7, 1, 0, 0, 0, 4'd1, FETCHR);
        cyc("h_decode",   4'd7, 1, 0, 0, 0, 4'd2, NONE);
        cyc("halt1",      4'd0, 1, 0, 1, 1, 4'd8, HALTD);
        cyc("halt2",      4'd8, 0, 1, 0, 0, 4'd8, HALTD);
        cyc("halt3",      4'd3, 1, 0, 0, 1, 4'd8, HALTD);

        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
